// File: rtl/load_store_unit_pkg.sv
// Shared memory-control definitions: mem_ctrl field layout, access widths and
// the load/store unit state encoding. Used by this unit and the memory controller.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        WIDTH_W   = 2'b00,
        WIDTH_H   = 2'b01,
        WIDTH_B   = 2'b10,
        WIDTH_ILL = 2'b11
    } width_e;

    // Bit layout matches the mem_ctrl port: [3]=RW, [2:1]=width, [0]=sign-extend.
    typedef struct packed {
        logic   rw;
        width_e width;
        logic   sign;
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ1,
        ST_REQ2,
        ST_DONE
    } lsu_state_e;

    function automatic logic [3:0] width_mask(input width_e w);
        case (w)
            WIDTH_W: return 4'b1111;
            WIDTH_H: return 4'b0011;
            WIDTH_B: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte-lane placement for stores and rotate/merge/extend for loads.
// Store outputs cover both transactions at once; the load side follows the current part.
module lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  offs,
    input  width_e      width,
    input  logic        sign,
    input  logic        part,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    input  logic [31:0] rd_prev,
    output logic        split,
    output logic [3:0]  be_first,
    output logic [3:0]  be_second,
    output logic [31:0] wdata_first,
    output logic [31:0] wdata_second,
    output logic [31:0] rd_shift,
    output logic [31:0] ld_value
);

    logic [4:0]  sh;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [63:0] rd_wide;
    logic [31:0] raw;

    always_comb begin
        sh      = {offs, 3'b000};
        // Shifting into a double-width vector yields both halves of a split access.
        be_wide = {4'b0000, width_mask(width)} << offs;
        wd_wide = {32'h0, st_data} << sh;
        rd_wide = {rd_word, 32'h0} >> sh;

        split        = |be_wide[7:4];
        be_first     = be_wide[3:0];
        be_second    = be_wide[7:4];
        wdata_first  = wd_wide[31:0];
        wdata_second = wd_wide[63:32];

        // Upper half is rdata>>8o (first word); lower half is rdata<<8(4-o) (second word).
        rd_shift = part ? rd_wide[31:0] : rd_wide[63:32];
        raw      = rd_shift | (part ? rd_prev : '0);

        case (width)
            WIDTH_H: ld_value = {{16{sign & raw[15]}}, raw[15:0]};
            WIDTH_B: ld_value = {{24{sign & raw[7]}}, raw[7:0]};
            default: ld_value = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one CPU access becomes one or two word transactions on
// a request/acknowledge bus, with a no-acknowledge timeout per transaction.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mem_ctrl,
    input  logic [31:0] adrs,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] q,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_wadrs,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state_q, state_d;
    mem_ctrl_t        ctrl_q, ctrl_d;
    logic [31:0]      adrs_q, adrs_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      partial_q, partial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      q_q, q_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [29:0]      mem_wadrs_q, mem_wadrs_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    mem_ctrl_t   op_ctrl;
    logic [31:0] op_adrs;
    logic [31:0] op_data;
    logic        part;
    logic        split;
    logic [3:0]  be_first, be_second;
    logic [31:0] wdata_first, wdata_second;
    logic [31:0] rd_shift, ld_value;

    // In IDLE the aligner sees the live request so REQ1 can issue on the next edge.
    always_comb begin
        op_ctrl = (state_q == ST_IDLE) ? mem_ctrl_t'(mem_ctrl) : ctrl_q;
        op_adrs = (state_q == ST_IDLE) ? adrs : adrs_q;
        op_data = (state_q == ST_IDLE) ? data : data_q;
        part    = (state_q == ST_REQ2);
    end

    lane_align u_lane_align (
        .offs         (op_adrs[1:0]),
        .width        (op_ctrl.width),
        .sign         (op_ctrl.sign),
        .part         (part),
        .st_data      (op_data),
        .rd_word      (mem_rdata),
        .rd_prev      (partial_q),
        .split        (split),
        .be_first     (be_first),
        .be_second    (be_second),
        .wdata_first  (wdata_first),
        .wdata_second (wdata_second),
        .rd_shift     (rd_shift),
        .ld_value     (ld_value)
    );

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        adrs_d      = adrs_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        partial_d   = partial_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        q_d         = q_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wadrs_d = mem_wadrs_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctrl_d = op_ctrl;
                    adrs_d = adrs;
                    data_d = data;
                    busy_d = 1'b1;
                    if (op_ctrl.width == WIDTH_ILL) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ1;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_ctrl.rw;
                        mem_wadrs_d = adrs[31:2];
                        mem_be_d    = be_first;
                        mem_wdata_d = wdata_first;
                    end
                end
            end

            ST_REQ1, ST_REQ2: begin
                if (mem_ack) begin
                    if (state_q == ST_REQ1 && split) begin
                        state_d     = ST_REQ2;
                        cnt_d       = '0;
                        partial_d   = rd_shift;
                        mem_wadrs_d = mem_wadrs_q + 30'd1;
                        mem_be_d    = be_second;
                        mem_wdata_d = wdata_second;
                    end else begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        err_d     = 1'b0;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        if (!ctrl_q.rw) q_d = ld_value;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= mem_ctrl_t'('0);
            adrs_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            partial_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            q_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wadrs_q <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            adrs_q      <= adrs_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            partial_q   <= partial_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            q_q         <= q_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wadrs_q <= mem_wadrs_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        busy      = busy_q;
        done      = done_q;
        err       = err_q;
        q         = q_q;
        mem_req   = mem_req_q;
        mem_we    = mem_we_q;
        mem_wadrs = mem_wadrs_q;
        mem_be    = mem_be_q;
        mem_wdata = mem_wdata_q;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle initiator that turns one CPU load/store request into one or two word-wide memory transactions over a request/acknowledge bus. It sits between the execute stage and the data RAM port. It handles byte and half-word lane placement, sign/zero extension, and word-boundary-crossing accesses, which are split into two transactions. A no-acknowledge timeout converts a hung transaction into an error completion.

## Interface
Parameters:
- TIMEOUT, 16, cycles `mem_req` may stay unacknowledged before the access aborts (≥1).

Ports:
- clk_cpu  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mem_ctrl  in  4  [3]=RW (1 write), [2:1]=width (00 W, 01 H, 10 B, 11 illegal), [0]=sign-extend.
- adrs  in  32  byte address.
- data  in  32  store data, LSB-justified.
- busy  out  1  high from the cycle after an accepted `start` until `done`.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; timeout or illegal width.
- q  out  32  load result, valid with `done`, held until next `done`.
- mem_req  out  1  transaction request.
- mem_we  out  1  write transaction.
- mem_wadrs  out  30  word address.
- mem_be  out  4  byte enables, bit i = byte lane i.
- mem_wdata  out  32  lane-aligned write data.
- mem_ack  in  1  transaction complete; `mem_rdata` valid the same cycle.
- mem_rdata  in  32  read word.

## Operation
- Let o = adrs[1:0] and n = 4, 2 or 1 bytes for W, H, B. Let m = (1<<n)-1.
- Width 11: no bus activity; `done`+`err` the cycle after `start`, `q` unchanged.
- First transaction:
  - word adrs[31:2];
  - be = (m<<o)[3:0];
  - wdata = data<<8o.
- Split when o+n>4. Second transaction:
  - word adrs[31:2]+1, wrapping 0x3FFFFFFF→0;
  - be = m>>(4-o);
  - wdata = data>>8(4-o).
- Stores use byte enables only; no read-modify-write.
- Loads:
  - raw = (rdata1>>8o) | (split ? rdata2<<8(4-o) : 0);
  - q = raw masked to n bytes;
  - if mem_ctrl[0] is set, sign-extend from bit 8n-1.
- `mem_ctrl`, `adrs` and `data` are registered at `start`; input changes during `busy` are ignored.
- States:
  - IDLE: `start` with legal width → REQ1; illegal width → DONE with err.
  - REQ1: on ack, → REQ2 if split, else → DONE.
  - REQ2: on ack → DONE.
  - DONE: pulse `done`, → IDLE.
  - In REQ1 or REQ2, timeout → DONE with err=1; a pending second transaction is not issued.
- Timeout counter: cleared on entry to REQ1 and REQ2, increments each cycle without ack. Abort occurs in the cycle the count reaches TIMEOUT with no ack.
- An ack arriving in the same cycle as the timeout wins.
- `start` while busy is ignored (no queuing).
- `mem_ack` outside REQ1/REQ2 is ignored.

## Timing
- Reset value of every output: busy, done, err, mem_req, mem_we = 0; mem_wadrs, mem_be, mem_wdata, q = 0. State = IDLE, counter = 0.
- Reset mid-operation drops `mem_req` immediately (async) and discards the partial load.
- `mem_req`, `mem_we`, `mem_wadrs`, `mem_be` and `mem_wdata` are registered. They are stable while `mem_req`=1 and change only after an ack edge.
- Between REQ1 and REQ2, `mem_req` stays high with new address and enables in the cycle after the first ack.
- Latency, with `start` at cycle 0 and zero-wait ack (ack in the first req cycle):
  - non-split: req in cycle 1, `done` in cycle 2;
  - split: req in cycles 1–2, `done` in cycle 3.
- Each wait cycle adds one.
- `q` is updated in the same edge that raises `done`.

## Structure
- The mem_ctrl field positions and encodings (RW, WIDTH W/H/B, SIGN) and the FSM state enum go in the shared defines package. The memory controller and this unit both include that package.
- One sub-module, `lane_align`: combinational placement of store data and byte enables, and the load rotate/merge/extend, from (o, width, sign, part). It is instantiated once and driven by the FSM's current part.

## Test plan
- lw @0x100, mem_rdata=0xDEADBEEF, ack immediate → one req, wadrs=0x40, be=1111; `done` at cycle 2, q=0xDEADBEEF, err=0.
- lb signed @0x103, rdata=0x80000000 → be=1000, q=0xFFFFFF80. lbu at the same address → q=0x00000080.
- lhu @0x107, rdata1=0xAB000000, rdata2=0x000000CD:
  - req wadrs 0x41 be=1000, then 0x42 be=0001;
  - q=0x0000CDAB, `done` at cycle 3.
- sw data=0x11223344 @0xFFFFFFFE:
  - write 1: wadrs=0x3FFFFFFF, be=1100, wdata=0x33440000;
  - write 2: wadrs=0x0, be=0011, wdata=0x00001122.
- TIMEOUT=4, no ack → `mem_req` high for 4 cycles, then `done`+`err`=1 and `mem_req`=0. Repeat with a split access timing out in REQ2 → no third request.
- Reset asserted while in REQ2 → all outputs 0 asynchronously. After release, a new lw completes normally. Also: `start` pulsed while busy has no effect.
